// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the machine state loader.
// Record kinds, halt causes and the memory window check live here so the bench-facing encodings stay in one place.
package loader_pkg;

  localparam logic [1:0] REC_REG = 2'd0;
  localparam logic [1:0] REC_MEM = 2'd1;
  localparam logic [1:0] REC_GO  = 2'd2;

  localparam logic [1:0] HALT_NONE      = 2'd0;
  localparam logic [1:0] HALT_ZERO_INST = 2'd1;
  localparam logic [1:0] HALT_BUDGET    = 2'd2;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_HALTED
  } loader_state_t;

  // Widened to 33 bits so a window ending at the top of the address space cannot wrap.
  function automatic logic mem_in_range(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [32:0] words);
    logic [32:0] limit;
    limit = {1'b0, base} + words;
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/machine_state_loader_run_watchdog.sv
// Run watchdog: saturating cycle counter plus the halt decision and its recorded cause.
// A zero instruction wins over the budget when both fire together.
module run_watchdog
  import loader_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      inst,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  logic zero_hit;
  logic budget_hit;

  // The first RUN cycle still shows the fetch coming out of reset, so inst is ignored until cycles >= 1.
  always_comb begin
    zero_hit   = run && (cycles != '0) && (inst == 32'h0);
    budget_hit = run && (cycles == LAST_CYCLE);
    halt       = zero_hit || budget_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles     <= '0;
      halt_cause <= HALT_NONE;
    end else begin
      if (run && (cycles != '1))
        cycles <= cycles + CNT_W'(1);
      if (zero_hit)
        halt_cause <= HALT_ZERO_INST;
      else if (budget_hit)
        halt_cause <= HALT_BUDGET;
    end
  end

endmodule

// File: rtl/machine_state_loader.sv
// Preloads register file and data memory from a record stream, then releases the CPU and frames the run.
// The CPU is held in reset everywhere except RUN, so HALTED freezes state for the dump.
module machine_state_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 64,
  parameter logic [31:0] MEM_BASE   = 32'h0000_4000,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             mem_we,
  output logic [31:0]      mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_reset,
  input  logic [31:0]      inst,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycles,
  output logic             err
);

  loader_state_t state_q;
  loader_state_t state_d;
  logic          accept;
  logic          halt;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= ST_LOAD;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (in_kind == REC_GO))
          state_d = ST_START;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        cpu_reset = 1'b0;
        if (halt)
          state_d = ST_HALTED;
      end
      ST_HALTED: done = 1'b1;
      default:   state_d = ST_LOAD;
    endcase
  end

  // Write strobes are single-cycle; address/data simply hold their last value between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      mem_we <= 1'b0;
      if (accept) begin
        case (in_kind)
          REC_REG: begin
            if (in_addr[4:0] == 5'd0) begin
              err <= 1'b1;
            end else begin
              rf_we    <= 1'b1;
              rf_waddr <= in_addr[4:0];
              rf_wdata <= in_data;
            end
          end
          REC_MEM: begin
            if (mem_in_range(in_addr, MEM_BASE, 33'(MEM_WORDS))) begin
              mem_we    <= 1'b1;
              mem_waddr <= in_addr;
              mem_wdata <= in_data;
            end else begin
              err <= 1'b1;
            end
          end
          REC_GO:  ;
          default: err <= 1'b1;
        endcase
      end
    end
  end

  run_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .run        (state_q == ST_RUN),
    .inst       (inst),
    .halt       (halt),
    .halt_cause (halt_cause),
    .cycles     (cycles)
  );

endmodule

// File: doc/machine_state_loader.md
Name: machine_state_loader

Overview:
- Hardware counterpart of the end-of-run register/memory dump: builds the machine's starting state and frames the run.
- Accepts a stream of preload records and writes them into the register file and data memory through dedicated write ports, holding the CPU in reset the whole time.
- On a GO record, releases the CPU, counts cycles, and stops the run on halt (fetched instruction == 0) or on a cycle budget.
- Sits between the test/debug host interface and `machine`.

Parameters:
- MAX_CYCLES, 64, cycle budget after GO before forced stop (64 cycles = 640 time units at a 10-unit clock).
- MEM_BASE, 32'h0000_4000, first legal data-memory word index.
- MEM_WORDS, 1024, number of legal word indices starting at MEM_BASE.
- CNT_W, 16, width of the cycle counter; must satisfy 2**CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  preload record valid.
- in_ready  out  1  loader accepts the record this cycle.
- in_kind  in  2  record kind: 0 = REG, 1 = MEM, 2 = GO, 3 = reserved.
- in_addr  in  32  REG: register index in bits [4:0]; MEM: word index.
- in_data  in  32  value to write.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write index.
- rf_wdata  out  32  register-file write data.
- mem_we  out  1  data-memory write enable.
- mem_waddr  out  32  data-memory word index.
- mem_wdata  out  32  data-memory write data.
- cpu_reset  out  1  reset driven to `machine`.
- inst  in  32  the machine's current fetched instruction.
- done  out  1  run finished (sticky).
- halt_cause  out  2  cause of stop: 0 = none, 1 = inst == 0, 2 = budget reached.
- cycles  out  CNT_W  CPU cycles elapsed since GO.
- err  out  1  sticky flag: a preload record was rejected.

Behaviour:
- Reset: clk and reset are the only clock/reset. While reset is high at a rising edge, the next state is:
  - state LOAD; cpu_reset = 1; in_ready = 1;
  - rf_we = mem_we = 0, with address/data outputs at 0;
  - done = 0, halt_cause = 0, cycles = 0, err = 0.
  - Reset asserted in any state, including mid-run, gives exactly this; a run in progress is abandoned.
- States: LOAD, START, RUN, HALTED.
- LOAD:
  - in_ready = 1. A record is accepted when in_valid && in_ready at a rising edge.
  - REG record: rf_we/rf_waddr/rf_wdata are registered and asserted for exactly one cycle, on the cycle after acceptance (1-cycle latency).
  - REG record with index 0: no write; err is set.
  - MEM record: mem_we asserts one cycle after acceptance when MEM_BASE <= in_addr < MEM_BASE+MEM_WORDS. If out of range: no write; err is set.
  - Back-to-back records are accepted every cycle. rf_we and mem_we are never both high.
  - GO record: no write; next state START.
  - Kind 3: discarded; err is set; stay in LOAD.
- START: in_ready = 0; cpu_reset still 1. This lets the last preload write land. Next state RUN unconditionally.
- RUN:
  - in_ready = 0; cpu_reset = 0.
  - cycles increments every cycle in RUN. It reads 1 at the end of the first RUN cycle.
  - inst is sampled only from the second RUN cycle onward (cycles >= 1), so the first fetch after reset is not misread.
  - Halt check (inst == 32'h0 while cycles >= 1): next state HALTED, halt_cause = 1.
  - Budget check (cycles == MAX_CYCLES-1 as the increment occurs): next state HALTED, halt_cause = 2.
  - Both halt conditions in the same cycle: halt_cause = 1 (inst halt has priority).
- HALTED:
  - cpu_reset = 1, freezing architectural state for the dump; done = 1.
  - cycles, halt_cause and err hold. in_ready = 0.
  - Exit only via reset.
- Counter: cycles saturates at its maximum and never wraps.
- err never clears except by reset, and does not block GO.

Decomposition:
- Shared package `loader_pkg` holds:
  - record-kind constants REC_REG, REC_MEM, REC_GO;
  - halt-cause constants HALT_NONE, HALT_ZERO_INST, HALT_BUDGET;
  - the state encoding.
- One natural sub-module, `run_watchdog`, owns:
  - the saturating cycle counter;
  - the inst == 0 / budget comparison and priority;
  - the halt_cause register.
- The write-port registers and the FSM stay in the top.

Test Plan:
- Register preload: REG(11, 123), REG(12, 100), REG(13, 268501000), REG(14, 268501004), REG(15, 100000) on consecutive cycles → rf_we pulses in 5 consecutive cycles with matching addr/data, one cycle after each acceptance; err = 0.
- Memory and errors: MEM(0x4000, 0xDEADBEEF) → mem_we pulse with that addr/data. Then MEM(0x3FFF, 1), REG(0, 5) and kind 3 → no write pulses; err = 1 and remains 1.
- Halt on zero instruction: preload, GO, drive inst nonzero for 10 cycles then 0 → cpu_reset low exactly from the cycle after START; done = 1; halt_cause = 1; cycles = 11; cpu_reset back to 1.
- Budget: GO with inst held at 32'h2000_0001 → done at cycles = 64; halt_cause = 2. Also drive inst = 0 on the 64th cycle → halt_cause = 1.
- Timing edges: inst = 0 in the first RUN cycle is ignored. Back-to-back GO immediately after a REG record → the REG write completes before cpu_reset falls.
- Reset mid-run: assert reset at cycles = 20 → state LOAD, cpu_reset = 1, cycles = 0, done = 0, err = 0, in_ready = 1 next cycle.
